// File: rtl/systolic_drain_pkg.sv
// Shared constants and row type for the systolic array output drain.
package systolic_drain_pkg;

    localparam int N           = 3;
    localparam int DATA_W_DFLT = 16;

    typedef struct packed {
        logic [DATA_W_DFLT-1:0] c1;
        logic [DATA_W_DFLT-1:0] c2;
        logic [DATA_W_DFLT-1:0] c3;
    } row_t;

endpackage

// File: rtl/row_fifo.sv
// Generic synchronous FIFO, DEPTH entries of WIDTH bits, head driven from storage.
// Latency: a push is visible at the head one cycle later; no bypass.
// Backpressure: push is refused when full unless a pop frees the slot in the same cycle.
module row_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// De-skews the array's bottom-row column streams into aligned rows, buffered for a valid/ready sink.
// Latency: in_valid at t gives out_valid at t+3 with the FIFO empty.
// Backpressure: out_ready low holds the head row; a row completing into a full FIFO is dropped and flags overflow.
module systolic_drain
    import systolic_drain_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_rows,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_col1,
    input  logic [DATA_W-1:0] in_col2,
    input  logic [DATA_W-1:0] in_col3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_row0,
    output logic [DATA_W-1:0] out_row1,
    output logic [DATA_W-1:0] out_row2,
    output logic [CNT_W-1:0]  rows_out,
    output logic              done,
    output logic              overflow
);

    localparam int ROW_W = N * DATA_W;

    logic [DATA_W-1:0] c1_d1;
    logic [DATA_W-1:0] c1_d2;
    logic [DATA_W-1:0] c2_d1;
    logic              vld_d1;
    logic              vld_d2;
    logic [ROW_W-1:0]  wr_row;
    logic [ROW_W-1:0]  head_row;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;
    logic [CNT_W-1:0]  num_lat;
    logic [CNT_W-1:0]  num_nxt;
    logic [CNT_W-1:0]  rows_nxt;
    logic              done_nxt;
    logic              ovf_nxt;

    // Column 1 waits two cycles and column 2 one cycle so all three line up with in_col3.
    always_ff @(posedge clk) begin
        if (rst) begin
            c1_d1  <= '0;
            c1_d2  <= '0;
            c2_d1  <= '0;
            vld_d1 <= 1'b0;
            vld_d2 <= 1'b0;
        end else begin
            c1_d1  <= in_col1;
            c1_d2  <= c1_d1;
            c2_d1  <= in_col2;
            vld_d1 <= in_valid;
            vld_d2 <= vld_d1;
        end
    end

    assign wr_row = {c1_d2, c2_d1, in_col3};
    assign pop    = out_valid && out_ready;
    assign drop   = vld_d2 && fifo_full && !pop;

    row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_d2),
        .pop   (pop),
        .din   (wr_row),
        .dout  (head_row),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid                      = !fifo_empty;
    assign {out_row0, out_row1, out_row2} = head_row;

    // start restarts the job counters but a pop in the same cycle already counts toward it.
    always_comb begin
        num_nxt  = start ? num_rows : num_lat;
        rows_nxt = start ? '0 : rows_out;
        done_nxt = start ? 1'b0 : done;
        ovf_nxt  = (start ? 1'b0 : overflow) | drop;
        if (pop && !(&rows_nxt)) begin
            rows_nxt = rows_nxt + CNT_W'(1);
        end
        if (pop && (rows_nxt == num_nxt) && (num_nxt != '0)) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_lat  <= '0;
            rows_out <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            num_lat  <= num_nxt;
            rows_out <= rows_nxt;
            done     <= done_nxt;
            overflow <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: directed skewed rows in, aligned rows checked out.
// Latency: expects out_valid three cycles after in_valid on an empty FIFO.
// Backpressure: exercises stalls, overflow drops, full push/pop, reset and start handling.
`timescale 1ns/1ps
module tb_systolic_drain;
    import systolic_drain_pkg::*;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_rows = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_col1 = '0;
    logic [DW-1:0] in_col2 = '0;
    logic [DW-1:0] in_col3 = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_row0;
    logic [DW-1:0] out_row1;
    logic [DW-1:0] out_row2;
    logic [CW-1:0] rows_out;
    logic          done;
    logic          overflow;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   first_pop = -1;
    int   last_pop = -1;
    row_t exp_q[$];
    row_t stim[10];
    row_t mon_row;
    row_t held;
    bit   stall_prev = 1'b0;

    systolic_drain #(.DATA_W(DW), .DEPTH(4), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_rows  (num_rows),
        .in_valid  (in_valid),
        .in_col1   (in_col1),
        .in_col2   (in_col2),
        .in_col3   (in_col3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row0  (out_row0),
        .out_row1  (out_row1),
        .out_row2  (out_row2),
        .rows_out  (rows_out),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks the head holds while stalled.
    always @(negedge clk) begin
        mon_row = {out_row0, out_row1, out_row2};
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) check("hold_stable", mon_row, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_row: got 0x%0h expected no row", mon_row);
                end else begin
                    check("row_data", mon_row, exp_q.pop_front());
                end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            stall_prev = out_valid && !out_ready;
            held       = mon_row;
        end
    end

    task automatic set_stim(input logic [DW-1:0] b1, input logic [DW-1:0] b2, input logic [DW-1:0] b3);
        for (int k = 0; k < 10; k++) begin
            stim[k].c1 = b1 + DW'(k);
            stim[k].c2 = b2 + DW'(k);
            stim[k].c3 = b3 + DW'(k);
        end
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        @(posedge clk); #1;
        start    = 1'b1;
        num_rows = n;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Feeds n back-to-back rows with the array's column skew; optional drop/ready/reset hooks by cycle.
    task automatic drive_rows(input int n, input int drop, input int ready_at, input int rst_at);
        for (int i = 0; i <= n + 1; i++) begin
            @(posedge clk); #1;
            if (i == 0) t0 = cyc;
            in_valid = (i < n);
            in_col1  = (i < n) ? stim[i].c1 : '0;
            in_col2  = (i >= 1 && i <= n) ? stim[i-1].c2 : '0;
            in_col3  = (i >= 2) ? stim[i-2].c3 : '0;
            if (i < n && i != drop) exp_q.push_back(stim[i]);
            if (i == ready_at) out_ready = 1'b1;
            if (i == rst_at) begin
                rst = 1'b1;
                exp_q.delete();
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_col1  = '0;
        in_col2  = '0;
        in_col3  = '0;
        rst      = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_row", {out_row0, out_row1, out_row2}, 0);
        check("rst_rows_out", rows_out, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single row with latency probe.
        out_ready = 1'b1;
        do_start(8'd1);
        stim[0] = {16'h0001, 16'h0002, 16'h0003};
        in_valid = 1'b1;
        in_col1  = 16'h0001;
        exp_q.push_back(stim[0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_col1  = '0;
        in_col2  = 16'h0002;
        @(posedge clk); #1;
        in_col2  = '0;
        in_col3  = 16'h0003;
        @(negedge clk);
        check("single_valid_t2", out_valid, 0);
        @(posedge clk); #1;
        in_col3  = '0;
        @(negedge clk);
        check("single_valid_t3", out_valid, 1);
        @(posedge clk);
        @(negedge clk);
        check("single_rows_out", rows_out, 1);
        check("single_done", done, 1);
        check("single_empty", out_valid, 0);

        // Streaming eight rows with no gaps.
        set_stim(16'd0, 16'd16, 16'd32);
        do_start(8'd8);
        first_pop = -1;
        drive_rows(8, -1, -1, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stream_rows_out", rows_out, 8);
        check("stream_done", done, 1);
        check("stream_first_lat", first_pop - t0, 3);
        check("stream_no_gap", last_pop - first_pop, 7);

        // Backpressure: fifth row overflows a full FIFO and is lost.
        set_stim(16'h0100, 16'h0200, 16'h0300);
        out_ready = 1'b0;
        do_start(8'd4);
        drive_rows(5, 4, -1, -1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ovf_flag", overflow, 1);
        check("ovf_valid", out_valid, 1);
        check("ovf_head", {out_row0, out_row1, out_row2}, stim[0]);
        check("ovf_rows_out", rows_out, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("ovf_drained", rows_out, 4);
        check("ovf_done", done, 1);
        check("ovf_empty", out_valid, 0);
        check("ovf_scoreboard", exp_q.size(), 0);

        // Full FIFO with a pop in the cycle the fifth row completes.
        set_stim(16'h0400, 16'h0500, 16'h0600);
        out_ready = 1'b0;
        do_start(8'd5);
        drive_rows(5, -1, 6, -1);
        @(negedge clk);
        check("fullpp_no_ovf", overflow, 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("fullpp_rows_out", rows_out, 5);
        check("fullpp_done", done, 1);
        check("fullpp_scoreboard", exp_q.size(), 0);

        // Reset with two rows buffered and one in the skew pipeline.
        set_stim(16'h0700, 16'h0800, 16'h0900);
        out_ready = 1'b0;
        drive_rows(3, -1, -1, 4);
        @(negedge clk);
        check("mrst_valid", out_valid, 0);
        check("mrst_rows_out", rows_out, 0);
        check("mrst_done", done, 0);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mrst_no_stale", out_valid, 0);

        // start with num_rows=0 never completes.
        set_stim(16'h0a00, 16'h0b00, 16'h0c00);
        do_start(8'd0);
        drive_rows(3, -1, -1, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("zero_rows_out", rows_out, 3);
        check("zero_done", done, 0);

        // Overflow, then start coincident with a pop.
        set_stim(16'h0d00, 16'h0e00, 16'h0f00);
        out_ready = 1'b0;
        drive_rows(5, 4, -1, -1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("st_ovf_set", overflow, 1);
        @(posedge clk); #1;
        start     = 1'b1;
        num_rows  = 8'd2;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        @(negedge clk);
        check("st_rows_out1", rows_out, 1);
        check("st_ovf_clear", overflow, 0);
        check("st_done_early", done, 0);
        @(posedge clk);
        @(negedge clk);
        check("st_rows_out2", rows_out, 2);
        check("st_done", done, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("st_rows_out4", rows_out, 4);
        check("st_done_sticky", done, 1);
        check("final_scoreboard", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
